// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO between a UART receiver shift register and a consumer
// Bytes are captured on the rising edge of NINTI; reads return registered data one cycle later.
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          CLOCK_RX,
  input  logic          NRESET,
  input  logic          NINTI,
  input  logic [7:0]    RX_DATA,
  input  logic          RD_EN,
  input  logic          OVR_CLR,
  output logic [7:0]    RD_DATA,
  output logic          RD_VALID,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   COUNT,
  output logic          OVERRUN
);

  typedef enum logic {EMPTY_ST = 1'b0, ACTIVE_ST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count_q, count_d;
  logic            full_q, full_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      rd_data_q;
  logic            rd_valid_q;
  logic            ninti_d;
  logic            wr_strobe, rd_acc, wr_acc;

  // Only the 0->1 transition of NINTI marks a completed byte; a held-high level never writes.
  assign wr_strobe = !ninti_d && NINTI;
  assign rd_acc    = RD_EN && (state_q == ACTIVE_ST);
  assign wr_acc    = wr_strobe && (!full_q || rd_acc);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (wr_acc && !rd_acc)
      count_d = count_q + (AW+1)'(1);
    else if (rd_acc && !wr_acc)
      count_d = count_q - (AW+1)'(1);
    full_d = (count_d == (AW+1)'(DEPTH));
    case (state_q)
      EMPTY_ST:  if (wr_acc) state_d = ACTIVE_ST;
      ACTIVE_ST: if (count_q == (AW+1)'(1) && rd_acc && !wr_acc) state_d = EMPTY_ST;
      default:   state_d = EMPTY_ST;
    endcase
    // Set wins over a same-cycle clear.
    if (wr_strobe && !wr_acc)
      overrun_d = 1'b1;
    else if (OVR_CLR)
      overrun_d = 1'b0;
  end

  always_ff @(posedge CLOCK_RX or negedge NRESET) begin
    if (!NRESET) begin
      state_q    <= EMPTY_ST;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overrun_q  <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      ninti_d    <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overrun_q  <= overrun_d;
      ninti_d    <= NINTI;
      rd_valid_q <= rd_acc;
      if (wr_acc)
        wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr    <= rd_ptr + AW'(1);
        rd_data_q <= mem[rd_ptr];
      end
    end
  end

  // Storage carries no reset; stale entries are never read because rd_acc requires occupancy.
  always_ff @(posedge CLOCK_RX) begin
    if (wr_acc)
      mem[wr_ptr] <= RX_DATA;
  end

  assign RD_DATA  = rd_data_q;
  assign RD_VALID = rd_valid_q;
  assign EMPTY    = (state_q == EMPTY_ST);
  assign FULL     = full_q;
  assign COUNT    = count_q;
  assign OVERRUN  = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       CLOCK_RX;
  logic       NRESET;
  logic       NINTI;
  logic [7:0] RX_DATA;
  logic       RD_EN;
  logic       OVR_CLR;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       EMPTY;
  logic       FULL;
  logic [3:0] COUNT;
  logic       OVERRUN;

  int checks;
  int failures;

  uart_rx_fifo #(.DEPTH(8), .AW(3)) dut (
    .CLOCK_RX(CLOCK_RX),
    .NRESET(NRESET),
    .NINTI(NINTI),
    .RX_DATA(RX_DATA),
    .RD_EN(RD_EN),
    .OVR_CLR(OVR_CLR),
    .RD_DATA(RD_DATA),
    .RD_VALID(RD_VALID),
    .EMPTY(EMPTY),
    .FULL(FULL),
    .COUNT(COUNT),
    .OVERRUN(OVERRUN)
  );

  initial CLOCK_RX = 1'b0;
  always #5 CLOCK_RX = ~CLOCK_RX;

  task automatic step();
    @(posedge CLOCK_RX);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d);
    NINTI = 1'b0;
    RX_DATA = d;
    step();
    NINTI = 1'b1;
    step();
  endtask

  task automatic read_byte(input logic [7:0] exp, input string name);
    RD_EN = 1'b1;
    step();
    RD_EN = 1'b0;
    checks++;
    if (RD_VALID !== 1'b1 || RD_DATA !== exp) begin
      failures++;
      $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h", name, RD_VALID, RD_DATA, exp);
    end
  endtask

  task automatic test_reset();
    NRESET = 1'b0;
    NINTI = 1'b1;
    RX_DATA = 8'h00;
    RD_EN = 1'b0;
    OVR_CLR = 1'b0;
    step();
    step();
    checks++;
    if (COUNT !== 4'd0 || EMPTY !== 1'b1 || FULL !== 1'b0 || OVERRUN !== 1'b0 ||
        RD_VALID !== 1'b0 || RD_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b ovr=%b valid=%b data=%h, required 0 1 0 0 0 00",
               COUNT, EMPTY, FULL, OVERRUN, RD_VALID, RD_DATA);
    end
    NRESET = 1'b1;
    step();
    step();
    checks++;
    if (COUNT !== 4'd0) begin
      failures++;
      $display("FAIL reset_release_no_write: count=%0d, required 0", COUNT);
    end
  endtask

  task automatic test_single_byte();
    send_byte(8'hA5);
    checks++;
    if (EMPTY !== 1'b0 || COUNT !== 4'd1) begin
      failures++;
      $display("FAIL single_write: empty=%b count=%0d, required empty=0 count=1", EMPTY, COUNT);
    end
    step();
    checks++;
    if (COUNT !== 4'd1) begin
      failures++;
      $display("FAIL single_level_high: count=%0d, required 1", COUNT);
    end
    read_byte(8'hA5, "single_read");
    checks++;
    if (EMPTY !== 1'b1 || COUNT !== 4'd0) begin
      failures++;
      $display("FAIL single_empty_after: empty=%b count=%0d, required empty=1 count=0", EMPTY, COUNT);
    end
    step();
    checks++;
    if (RD_VALID !== 1'b0 || RD_DATA !== 8'hA5) begin
      failures++;
      $display("FAIL single_pulse: valid=%b data=%h, required valid=0 data=a5", RD_VALID, RD_DATA);
    end
  endtask

  task automatic test_fill_overrun();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    checks++;
    if (FULL !== 1'b1 || COUNT !== 4'd8 || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: full=%b count=%0d ovr=%b, required 1 8 0", FULL, COUNT, OVERRUN);
    end
    send_byte(8'h09);
    checks++;
    if (OVERRUN !== 1'b1 || COUNT !== 4'd8) begin
      failures++;
      $display("FAIL fill_overrun: ovr=%b count=%0d, required 1 8", OVERRUN, COUNT);
    end
    for (int i = 1; i <= 8; i++) read_byte(8'(i), "fill_read_order");
    checks++;
    if (EMPTY !== 1'b1 || COUNT !== 4'd0) begin
      failures++;
      $display("FAIL fill_09_absent: empty=%b count=%0d, required empty=1 count=0", EMPTY, COUNT);
    end
    checks++;
    if (OVERRUN !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: ovr=%b, required 1", OVERRUN);
    end
    OVR_CLR = 1'b1;
    step();
    OVR_CLR = 1'b0;
    checks++;
    if (OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL overrun_clear: ovr=%b, required 0", OVERRUN);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] d;
    for (int i = 0; i < 20; i++) begin
      d = 8'((i * 37 + 11) ^ 8'h5A);
      send_byte(d);
      checks++;
      if (COUNT !== 4'd1) begin
        failures++;
        $display("FAIL wrap_count_%0d: count=%0d, required 1", i, COUNT);
      end
      read_byte(d, "wrap_read");
    end
    checks++;
    if (COUNT !== 4'd0 || EMPTY !== 1'b1) begin
      failures++;
      $display("FAIL wrap_end: count=%0d empty=%b, required 0 1", COUNT, EMPTY);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    NINTI = 1'b0;
    RX_DATA = 8'h55;
    step();
    NINTI = 1'b1;
    RD_EN = 1'b1;
    step();
    RD_EN = 1'b0;
    checks++;
    if (COUNT !== 4'd8 || OVERRUN !== 1'b0 || FULL !== 1'b1 || RD_VALID !== 1'b1 || RD_DATA !== 8'h10) begin
      failures++;
      $display("FAIL full_rw: count=%0d ovr=%b full=%b valid=%b data=%h, required 8 0 1 1 10",
               COUNT, OVERRUN, FULL, RD_VALID, RD_DATA);
    end
    for (int i = 1; i < 8; i++) read_byte(8'h10 + 8'(i), "full_rw_drain");
    read_byte(8'h55, "full_rw_newest");
    NINTI = 1'b0;
    RX_DATA = 8'h66;
    step();
    NINTI = 1'b1;
    RD_EN = 1'b1;
    step();
    RD_EN = 1'b0;
    checks++;
    if (RD_VALID !== 1'b0 || COUNT !== 4'd1 || RD_DATA !== 8'h55) begin
      failures++;
      $display("FAIL empty_rw: valid=%b count=%0d data=%h, required 0 1 55", RD_VALID, COUNT, RD_DATA);
    end
    read_byte(8'h66, "empty_rw_read");
  endtask

  task automatic test_read_empty();
    RD_EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (RD_VALID !== 1'b0 || RD_DATA !== 8'h66 || COUNT !== 4'd0) begin
        failures++;
        $display("FAIL read_empty_%0d: valid=%b data=%h count=%0d, required 0 66 0", i, RD_VALID, RD_DATA, COUNT);
      end
    end
    RD_EN = 1'b0;
  endtask

  task automatic test_reset_mid();
    send_byte(8'hC1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    NINTI = 1'b0;
    step();
    #2;
    NRESET = 1'b0;
    #1;
    checks++;
    if (COUNT !== 4'd0 || EMPTY !== 1'b1 || FULL !== 1'b0 || OVERRUN !== 1'b0 ||
        RD_VALID !== 1'b0 || RD_DATA !== 8'h00) begin
      failures++;
      $display("FAIL reset_async: count=%0d empty=%b full=%b ovr=%b valid=%b data=%h, required 0 1 0 0 0 00",
               COUNT, EMPTY, FULL, OVERRUN, RD_VALID, RD_DATA);
    end
    NINTI = 1'b1;
    step();
    step();
    NRESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (COUNT !== 4'd0) begin
        failures++;
        $display("FAIL reset_mid_hold_%0d: count=%0d, required 0", i, COUNT);
      end
    end
    send_byte(8'h77);
    checks++;
    if (COUNT !== 4'd1) begin
      failures++;
      $display("FAIL reset_mid_new_write: count=%0d, required 1", COUNT);
    end
    read_byte(8'h77, "reset_mid_read");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single_byte();
    test_fill_overrun();
    test_wrap();
    test_simultaneous();
    test_read_empty();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
